// File: rtl/alu_pipe.sv
// Two-stage add/sub/min/max ALU with accumulator, optional saturation and flags; result 1 cycle after accept.
// Holds 2 transactions; stalls on !out_ready, and in_ready follows out_ready combinationally when S1 is occupied.
module alu_pipe #(
  parameter int WIDTH    = 9,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       select,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf,
  output logic             out_zero
);

  typedef struct packed {
    logic [1:0]       sel;
    logic             acc_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  s1_t              s1;
  logic             s1_valid;
  logic             s2_adv;
  logic [WIDTH-1:0] acc;

  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   ea;
  logic [WIDTH:0]   eb;
  logic [WIDTH:0]   raw;
  logic             lt;
  logic             arith_ovf;
  logic [WIDTH-1:0] clamp;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1 <= '{sel: select, acc_en: acc_en, a: inputA, b: inputB};
      end
    end
  end

  // B is taken from the accumulator here, at S2, so chained accumulates see the previous result.
  always_comb begin
    op_b      = s1.acc_en ? acc : s1.b;
    ea        = {(SIGNED ? s1.a[WIDTH-1] : 1'b0), s1.a};
    eb        = {(SIGNED ? op_b[WIDTH-1] : 1'b0), op_b};
    raw       = s1.sel[0] ? (ea - eb) : (ea + eb);
    lt        = $signed(ea) < $signed(eb);
    arith_ovf = SIGNED ? (raw[WIDTH] ^ raw[WIDTH-1]) : raw[WIDTH];
    if (SIGNED) begin
      clamp = raw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      clamp = s1.sel[0] ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end
    res     = s1.a;
    res_ovf = 1'b0;
    if (s1.sel[1]) begin
      res = (lt ^ s1.sel[0]) ? s1.a : op_b;
    end else begin
      res_ovf = arith_ovf;
      res     = (arith_ovf && SATURATE) ? clamp : raw[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out      <= res;
        out_ovf  <= res_ovf;
        out_zero <= (res == '0);
      end
    end
  end

  // An accumulating load takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (s2_adv && s1_valid && s1.acc_en) begin
      acc <= res;
    end else if (acc_clr) begin
      acc <= '0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: four builds (signed/unsigned x saturate/wrap) share one stimulus stream.
module tb_alu_pipe;
  localparam int W = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, acc_en, acc_clr, out_ready;
  logic [1:0]   select;
  logic [W-1:0] inputA, inputB;

  logic         ir [4];
  logic         ov [4];
  logic         oo [4];
  logic         oz [4];
  logic [W-1:0] o  [4];
  logic [W-1:0] acc_w [4];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 4; g++) begin : gd
    alu_pipe #(.WIDTH(W), .SIGNED(g < 2), .SATURATE(g % 2 == 0)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[g]),
      .select(select), .acc_en(acc_en), .acc_clr(acc_clr),
      .inputA(inputA), .inputB(inputB), .out_valid(ov[g]), .out_ready(out_ready),
      .out(o[g]), .out_ovf(oo[g]), .out_zero(oz[g]));
    assign acc_w[g] = dut.acc;
  end

  function automatic bit cfg_s(int g); return g < 2;      endfunction
  function automatic bit cfg_t(int g); return g % 2 == 0; endfunction

  // Reference: exact integer result, range check, then clamp or wrap.
  function automatic logic [W:0] ref_op(logic [1:0] sel, logic [W-1:0] a, logic [W-1:0] b,
                                        bit sgn, bit sat);
    int va, vb, r, lo, hi;
    bit ovf;
    logic [31:0] rb;
    va = (sgn && a[W-1]) ? int'(a) - (1 << W) : int'(a);
    vb = (sgn && b[W-1]) ? int'(b) - (1 << W) : int'(b);
    lo = sgn ? -(1 << (W-1)) : 0;
    hi = sgn ? (1 << (W-1)) - 1 : (1 << W) - 1;
    case (sel)
      2'd0:    r = va + vb;
      2'd1:    r = va - vb;
      2'd2:    r = (va < vb) ? va : vb;
      default: r = (va > vb) ? va : vb;
    endcase
    ovf = (r < lo) || (r > hi);
    if (ovf && sat) r = (r < lo) ? lo : hi;
    rb = r;
    return {ovf, rb[W-1:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: in-flight transactions in acceptance order; the head becomes the visible result once loaded.
  typedef struct packed {
    logic [1:0]          sel;
    logic                acc_en;
    logic [W-1:0]        a;
    logic [W-1:0]        b;
    logic                loaded;
    logic [3:0][W-1:0]   res;
    logic [3:0]          ovf;
  } item_t;

  item_t        mq[$];
  logic [W-1:0] macc [4];
  item_t        it;
  logic [W:0]   rr;
  bit           pop, ld, acc_ok;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      for (int g = 0; g < 4; g++) macc[g] = '0;
    end else begin
      acc_ok = in_valid && ((mq.size() < 2) || out_ready);
      pop    = (mq.size() > 0) && mq[0].loaded && out_ready;
      if (pop) void'(mq.pop_front());
      ld = 1'b0;
      if (mq.size() > 0 && !mq[0].loaded) begin
        it = mq[0];
        for (int g = 0; g < 4; g++) begin
          rr = ref_op(it.sel, it.a, it.acc_en ? macc[g] : it.b, cfg_s(g), cfg_t(g));
          it.res[g] = rr[W-1:0];
          it.ovf[g] = rr[W];
        end
        it.loaded = 1'b1;
        mq[0] = it;
        ld = 1'b1;
      end
      for (int g = 0; g < 4; g++) begin
        if (ld && it.acc_en) macc[g] = it.res[g];
        else if (acc_clr)    macc[g] = '0;
      end
      if (acc_ok) begin
        it = '0;
        it.sel = select; it.acc_en = acc_en; it.a = inputA; it.b = inputB;
        mq.push_back(it);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int g = 0; g < 4; g++) begin
        bit hv;
        hv = (mq.size() > 0) && mq[0].loaded;
        chk($sformatf("in_ready[%0d]", g), ir[g], (mq.size() < 2) || out_ready);
        chk($sformatf("out_valid[%0d]", g), ov[g], hv);
        if (hv) begin
          chk($sformatf("out[%0d]", g), o[g], mq[0].res[g]);
          chk($sformatf("out_ovf[%0d]", g), oo[g], mq[0].ovf[g]);
          chk($sformatf("out_zero[%0d]", g), oz[g], mq[0].res[g] == '0);
        end
        chk($sformatf("acc[%0d]", g), acc_w[g], macc[g]);
      end
    end
  end

  logic [W-1:0] outlog[$];
  always @(negedge clk) if (!reset && ov[0] && out_ready) outlog.push_back(o[0]);

  task automatic step(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic idle();
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic op(logic [1:0] s, logic [W-1:0] a, logic [W-1:0] b, logic ae);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; select = s; inputA = a; inputB = b; acc_en = ae;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk); done = ir[0];
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL op_accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic single(logic [1:0] s, logic [W-1:0] a, logic [W-1:0] b);
    op(s, a, b, 1'b0); idle(); step(3);
  endtask

  initial begin
    int nacc;
    reset = 1'b1; out_ready = 1'b1; select = '0; inputA = '0; inputB = '0;
    idle();
    step(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", ov[0], 0); chk("rst_out", o[0], 0);
    chk("rst_ovf", oo[0], 0);       chk("rst_zero", oz[0], 0);
    chk("rst_in_ready", ir[0], 1);  chk("rst_acc", acc_w[0], 0);
    @(posedge clk); #1;

    chk("pin_add_sat",   ref_op(2'd0, 9'd200, 9'd100, 1, 1), 10'h2FF);
    chk("pin_add_wrap",  ref_op(2'd0, 9'd200, 9'd100, 1, 0), 10'h32C);
    chk("pin_sub_sat",   ref_op(2'd1, 9'h138, 9'd100, 1, 1), 10'h300);
    chk("pin_add_zero",  ref_op(2'd0, 9'd5,   9'h1FB, 1, 1), 10'h000);
    chk("pin_min",       ref_op(2'd2, 9'h1FB, 9'd3,   1, 1), 10'h1FB);
    chk("pin_max",       ref_op(2'd3, 9'h1FB, 9'd3,   1, 1), 10'h003);
    chk("pin_uadd_wrap", ref_op(2'd0, 9'd400, 9'd200, 0, 0), 10'h258);
    chk("pin_usub_wrap", ref_op(2'd1, 9'd3,   9'd5,   0, 0), 10'h3FE);

    single(2'd0, 9'd200, 9'd100);
    chk("add_sat_out", o[0], 9'h0FF); chk("add_sat_ovf", oo[0], 1); chk("add_wrap_out", o[1], 9'h12C);
    single(2'd1, 9'h138, 9'd100);
    chk("sub_sat_out", o[0], 9'h100); chk("sub_sat_ovf", oo[0], 1);
    single(2'd0, 9'd5, 9'h1FB);
    chk("zero_out", o[0], 0); chk("zero_flag", oz[0], 1); chk("zero_ovf", oo[0], 0);
    single(2'd2, 9'h1FB, 9'd3);
    chk("min_out", o[0], 9'h1FB); chk("min_ovf", oo[0], 0);
    single(2'd3, 9'h1FB, 9'd3);
    chk("max_out", o[0], 9'h003);
    single(2'd0, 9'd400, 9'd200);
    chk("uadd_out", o[3], 9'd88); chk("uadd_ovf", oo[3], 1);
    single(2'd1, 9'd3, 9'd5);
    chk("usub_out", o[3], 9'd510); chk("usub_ovf", oo[3], 1); chk("usub_sat_out", o[2], 0);

    // Back-pressure: four offers with the consumer stalled.
    outlog.delete();
    out_ready = 1'b0; nacc = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; select = 2'd0; acc_en = 1'b0;
      inputA = 9'(10 * i + 1); inputB = 9'(i);
      @(negedge clk);
      if (ir[0]) nacc++;
      if (i >= 2) begin
        chk("bp_in_ready_low", ir[0], 0);
        chk("bp_hold_out", o[0], 1);
      end
      @(posedge clk); #1;
    end
    chk("bp_accepts", nacc, 2);
    out_ready = 1'b1;
    op(2'd0, 9'd21, 9'd2, 1'b0);
    op(2'd0, 9'd31, 9'd3, 1'b0);
    idle(); step(4);
    chk("bp_count", outlog.size(), 4);
    if (outlog.size() == 4) begin
      chk("bp_r0", outlog[0], 1);  chk("bp_r1", outlog[1], 12);
      chk("bp_r2", outlog[2], 23); chk("bp_r3", outlog[3], 34);
    end

    // Accumulator chain, then clear coinciding with the third load.
    op(2'd0, 9'd7, 9'd0, 1'b1); idle(); step(3);
    acc_clr = 1'b1; step(1); acc_clr = 1'b0;
    chk("acc_cleared", acc_w[0], 0);
    outlog.delete();
    repeat (3) op(2'd0, 9'd10, 9'd0, 1'b1);
    idle(); step(4);
    chk("acc_chain", acc_w[0], 30);
    chk("acc_count", outlog.size(), 3);
    if (outlog.size() == 3) begin
      chk("acc_r0", outlog[0], 10); chk("acc_r1", outlog[1], 20); chk("acc_r2", outlog[2], 30);
    end
    acc_clr = 1'b1; step(1); acc_clr = 1'b0;
    repeat (3) op(2'd0, 9'd10, 9'd0, 1'b1);
    idle(); acc_clr = 1'b1; step(1); acc_clr = 1'b0; step(3);
    chk("acc_load_wins", acc_w[0], 30);

    // Reset with both stages full.
    out_ready = 1'b0;
    op(2'd0, 9'd50, 9'd0, 1'b1);
    op(2'd0, 9'd60, 9'd0, 1'b1);
    reset = 1'b1; step(1);
    reset = 1'b0; idle();
    @(negedge clk);
    chk("mid_rst_valid", ov[0], 0); chk("mid_rst_out", o[0], 0); chk("mid_rst_acc", acc_w[0], 0);
    @(posedge clk); #1;
    out_ready = 1'b1; outlog.delete(); step(5);
    chk("mid_rst_no_stale", outlog.size(), 0);

    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 499) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      select    = 2'($urandom);
      acc_en    = ($urandom_range(0, 3) == 0);
      acc_clr   = ($urandom_range(0, 19) == 0);
      inputA    = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 9'h0FF : 9'h100) : 9'($urandom);
      inputB    = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 9'h1FF : 9'h001) : 9'($urandom);
      step(1);
    end
    reset = 1'b0; idle(); out_ready = 1'b1; step(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the team's 9-bit combinational ALU. It performs add, subtract, min and max on WIDTH-bit operands. It adds a signed/unsigned mode, optional saturation, overflow/zero flags, an internal accumulator and a valid/ready handshake on both sides. It sits between the operand fetch logic and the result write-back in the TPU datapath, and it can stall on back-pressure.

## Interface
- WIDTH, 9: operand and result width in bits (≥ 2).
- SIGNED, 1: 1 = two's-complement operands, 0 = unsigned.
- SATURATE, 1: 1 = clamp add/sub results to the representable range, 0 = wrap modulo 2^WIDTH.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts the input this cycle.
- select  in  2  op: 00 add, 01 sub (A−B), 10 min, 11 max.
- acc_en  in  1  use the accumulator as operand B and write the result back to the accumulator.
- acc_clr  in  1  clear the accumulator; independent of in_valid.
- inputA, inputB  in  WIDTH  operands. inputB is ignored when acc_en=1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  result.
- out_ovf  out  1  add/sub overflowed (clamped or wrapped).
- out_zero  out  1  out == 0.

## Operation
- Two-stage pipeline:
  - S1 registers A, B, select, acc_en, valid.
  - S2 selects operand B (S1 B, or acc when acc_en), computes the result, and registers out, out_ovf, out_zero and out_valid.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_valid || s2_adv.
- Input accept = in_valid && in_ready. An S2 load occurs when s2_adv && s1_valid.
- Arithmetic:
  - Compute in WIDTH+1 bits, sign-extended if SIGNED, else zero-extended.
  - Overflow when the extended result lies outside the WIDTH-bit range. The signed range is −2^(WIDTH−1)..2^(WIDTH−1)−1; the unsigned range is 0..2^WIDTH−1.
  - SATURATE=1: clamp to the nearest range bound. SATURATE=0: truncate.
  - out_ovf is set in both cases.
- Unsigned sub underflow (A<B): out_ovf=1; the result is 0 when saturating.
- min/max compare per SIGNED mode. They never set out_ovf.
- Accumulator:
  - WIDTH-bit register, reset to 0.
  - On an S2 load with acc_en=1, acc ← the stored result (post-saturation/wrap).
  - Because B is read at S2, back-to-back accumulate ops chain with no hazard.
  - acc_clr sets acc to 0 next cycle. If acc_clr coincides with an accumulating S2 load, the load wins.
- out_zero reflects the final stored result.
- Holding: while out_valid && !out_ready, out/out_ovf/out_zero stay stable, and S1 holds if occupied.

## Timing
- Reset values: out_valid=0, out=0, out_ovf=0, out_zero=0, acc=0, S1 valid=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards both stages and the accumulator with no output produced. Inputs presented during reset are not accepted.
- Latency: a transaction accepted at edge N has out_valid=1 after edge N+1. Throughput is 1 per cycle when out_ready=1.
- Capacity is 2 transactions. With out_ready held low, in_ready drops after the second accept and rises combinationally in the cycle out_ready=1.
- in_ready depends combinationally on out_ready. No other combinational path runs from inputs to outputs.
- Results leave in acceptance order. None are dropped or duplicated.

## Test plan
- WIDTH=9, SIGNED=1, SATURATE=1:
  - add 200+100 → out=255 (0x0FF), ovf=1.
  - sub −200−100 → out=0x100 (−256), ovf=1.
  - add 5+(−5) → out=0, zero=1, ovf=0.
- Same configuration: min(−5,3) → 0x1FB, max(−5,3) → 0x003, ovf=0. Unsigned build (SIGNED=0, SATURATE=0): add 400+200 → 88, ovf=1; sub 3−5 → 510, ovf=1.
- Back-pressure: hold out_ready=0 and offer 4 back-to-back ops. Exactly 2 are accepted and in_ready=0 from the third cycle. Release out_ready; all 4 results emerge in order, one per cycle, with out stable while stalled.
- Accumulator:
  - Pulse acc_clr, then issue 3 back-to-back add acc_en=1, A=10 → outputs 10, 20, 30, then acc=30.
  - acc_clr asserted on the cycle of the third S2 load → acc=30 (load wins).
- Reset mid-stream: assert reset with both stages full → next cycle out_valid=0, out=0, acc=0, and no stale result appears afterwards.
- Random streams against a reference model across both SIGNED and SATURATE values, with random in_valid/out_ready, checking ordering and flag correctness.
